// File: rtl/dcache_store_drain.sv
// Store-buffer drain stage: pops the oldest store, writes it byte-enabled into the cache,
// and forwards misses to memory as a write-through. Optional perf counters: STORE_DRAIN_PERF_EN.
module dcache_store_drain #(
    parameter int ENTRY_W = 56
) (
    input  logic               clock,
    input  logic               reset,

    input  logic               sb_pending,
    input  logic               sb_full,
    input  logic [ENTRY_W-1:0] sb_oldest_info,
    output logic               sb_get_oldest,

    input  logic               load_busy,
    input  logic               drain_req,
    output logic               drain_done,

    output logic               dc_wr_valid,
    input  logic               dc_wr_ready,
    output logic [14:0]        dc_wr_tag,
    output logic [1:0]         dc_wr_way,
    output logic [2:0]         dc_wr_word,
    output logic [3:0]         dc_wr_byte_en,
    output logic [31:0]        dc_wr_data,

    input  logic               dc_rsp_valid,
    input  logic               dc_rsp_hit,

    output logic               mem_wr_valid,
    input  logic               mem_wr_ready,
    output logic [19:0]        mem_wr_addr,
    output logic [3:0]         mem_wr_byte_en,
    output logic [31:0]        mem_wr_data,
    input  logic               mem_wr_ack,

    output logic               busy,
    output logic [2:0]         dbg_state
`ifdef STORE_DRAIN_PERF_EN
    ,
    output logic [31:0]        perf_stores,
    output logic [31:0]        perf_misses
`endif
);

    // Handshakes: a transfer happens on a rising clock edge where valid and ready are both
    // high; once raised, valid and its payload stay constant until that transfer occurs.

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ISSUE    = 3'd1,
        WAIT_RSP = 3'd2,
        MEM_REQ  = 3'd3,
        MEM_WAIT = 3'd4
    } state_t;

    state_t state;

    logic [14:0] ent_tag;
    logic [4:0]  ent_off;
    logic [1:0]  ent_way;
    logic [1:0]  ent_size;
    logic [31:0] ent_data;
    logic [1:0]  lane;
    logic [3:0]  dec_byte_en;
    logic [31:0] dec_data;
    logic        launch;

    assign ent_tag  = sb_oldest_info[55:41];
    assign ent_off  = sb_oldest_info[40:36];
    assign ent_way  = sb_oldest_info[35:34];
    assign ent_size = sb_oldest_info[33:32];
    assign ent_data = sb_oldest_info[31:0];
    assign lane     = ent_off[1:0];

    // Lane steering is decoded before latching so the registered payload is ready in ISSUE.
    always_comb begin
        dec_byte_en = 4'hF;
        dec_data    = ent_data;
        case (ent_size)
            2'd0: begin
                dec_byte_en = 4'b0001 << lane;
                dec_data    = {24'h000000, ent_data[7:0]} << {lane, 3'b000};
            end
            2'd1: begin
                dec_byte_en = 4'b0011 << {lane[1], 1'b0};
                dec_data    = {16'h0000, ent_data[15:0]} << {lane[1], 4'b0000};
            end
            default: begin
                dec_byte_en = 4'hF;
                dec_data    = ent_data;
            end
        endcase
    end

    // Loads own the port unless the buffer is full or a drain is pending.
    assign launch        = sb_pending && (!load_busy || sb_full || drain_req);
    assign sb_get_oldest = !reset && (state == IDLE) && launch;
    assign drain_done    = drain_req && (state == IDLE) && !sb_pending;
    assign dbg_state     = state;

    // The memory write carries exactly the same lanes as the cache write.
    assign mem_wr_byte_en = dc_wr_byte_en;
    assign mem_wr_data    = dc_wr_data;

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            busy          <= 1'b0;
            dc_wr_valid   <= 1'b0;
            mem_wr_valid  <= 1'b0;
            dc_wr_tag     <= '0;
            dc_wr_way     <= '0;
            dc_wr_word    <= '0;
            dc_wr_byte_en <= '0;
            dc_wr_data    <= '0;
            mem_wr_addr   <= '0;
`ifdef STORE_DRAIN_PERF_EN
            perf_stores   <= '0;
            perf_misses   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (launch) begin
                        dc_wr_tag     <= ent_tag;
                        dc_wr_way     <= ent_way;
                        dc_wr_word    <= ent_off[4:2];
                        dc_wr_byte_en <= dec_byte_en;
                        dc_wr_data    <= dec_data;
                        mem_wr_addr   <= {ent_tag, ent_off};
                        dc_wr_valid   <= 1'b1;
                        busy          <= 1'b1;
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (dc_wr_ready) begin
                        dc_wr_valid <= 1'b0;
                        state       <= WAIT_RSP;
                    end
                end
                WAIT_RSP: begin
                    if (dc_rsp_valid) begin
                        if (dc_rsp_hit) begin
                            busy  <= 1'b0;
                            state <= IDLE;
`ifdef STORE_DRAIN_PERF_EN
                            if (perf_stores != 32'hFFFF_FFFF)
                                perf_stores <= perf_stores + 32'd1;
`endif
                        end else begin
                            mem_wr_valid <= 1'b1;
                            state        <= MEM_REQ;
`ifdef STORE_DRAIN_PERF_EN
                            if (perf_misses != 32'hFFFF_FFFF)
                                perf_misses <= perf_misses + 32'd1;
`endif
                        end
                    end
                end
                MEM_REQ: begin
                    if (mem_wr_ready) begin
                        mem_wr_valid <= 1'b0;
                        state        <= MEM_WAIT;
                    end
                end
                MEM_WAIT: begin
                    if (mem_wr_ack) begin
                        busy  <= 1'b0;
                        state <= IDLE;
`ifdef STORE_DRAIN_PERF_EN
                        if (perf_stores != 32'hFFFF_FFFF)
                            perf_stores <= perf_stores + 32'd1;
`endif
                    end
                end
                default: begin
                    dc_wr_valid  <= 1'b0;
                    mem_wr_valid <= 1'b0;
                    busy         <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_store_drain.sv
// Directed bench for dcache_store_drain; inputs change on the falling edge, outputs are
// sampled 1 ns later. Build with +define+STORE_DRAIN_PERF_EN to also cover the counters.
module tb_dcache_store_drain;

    logic        clock;
    logic        reset;
    logic        sb_pending;
    logic        sb_full;
    logic [55:0] sb_oldest_info;
    logic        sb_get_oldest;
    logic        load_busy;
    logic        drain_req;
    logic        drain_done;
    logic        dc_wr_valid;
    logic        dc_wr_ready;
    logic [14:0] dc_wr_tag;
    logic [1:0]  dc_wr_way;
    logic [2:0]  dc_wr_word;
    logic [3:0]  dc_wr_byte_en;
    logic [31:0] dc_wr_data;
    logic        dc_rsp_valid;
    logic        dc_rsp_hit;
    logic        mem_wr_valid;
    logic        mem_wr_ready;
    logic [19:0] mem_wr_addr;
    logic [3:0]  mem_wr_byte_en;
    logic [31:0] mem_wr_data;
    logic        mem_wr_ack;
    logic        busy;
    logic [2:0]  dbg_state;
`ifdef STORE_DRAIN_PERF_EN
    logic [31:0] perf_stores;
    logic [31:0] perf_misses;
`endif

    int checks_total;
    int checks_passed;

    dcache_store_drain #(.ENTRY_W(56)) dut (
        .clock          (clock),
        .reset          (reset),
        .sb_pending     (sb_pending),
        .sb_full        (sb_full),
        .sb_oldest_info (sb_oldest_info),
        .sb_get_oldest  (sb_get_oldest),
        .load_busy      (load_busy),
        .drain_req      (drain_req),
        .drain_done     (drain_done),
        .dc_wr_valid    (dc_wr_valid),
        .dc_wr_ready    (dc_wr_ready),
        .dc_wr_tag      (dc_wr_tag),
        .dc_wr_way      (dc_wr_way),
        .dc_wr_word     (dc_wr_word),
        .dc_wr_byte_en  (dc_wr_byte_en),
        .dc_wr_data     (dc_wr_data),
        .dc_rsp_valid   (dc_rsp_valid),
        .dc_rsp_hit     (dc_rsp_hit),
        .mem_wr_valid   (mem_wr_valid),
        .mem_wr_ready   (mem_wr_ready),
        .mem_wr_addr    (mem_wr_addr),
        .mem_wr_byte_en (mem_wr_byte_en),
        .mem_wr_data    (mem_wr_data),
        .mem_wr_ack     (mem_wr_ack),
        .busy           (busy),
        .dbg_state      (dbg_state)
`ifdef STORE_DRAIN_PERF_EN
        ,
        .perf_stores    (perf_stores),
        .perf_misses    (perf_misses)
`endif
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running want finished");
        $fatal(1);
    end

    function automatic logic [55:0] make_entry(input logic [14:0] tag, input logic [4:0] off,
                                               input logic [1:0] way, input logic [1:0] size,
                                               input logic [31:0] data);
        return {tag, off, way, size, data};
    endfunction

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic clear_inputs();
        sb_pending     = 1'b0;
        sb_full        = 1'b0;
        sb_oldest_info = '0;
        load_busy      = 1'b0;
        drain_req      = 1'b0;
        dc_wr_ready    = 1'b0;
        dc_rsp_valid   = 1'b0;
        dc_rsp_hit     = 1'b0;
        mem_wr_ready   = 1'b0;
        mem_wr_ack     = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        tick(); tick(); tick();
        #1;
        checks_total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %0h want 0", busy); else checks_passed++;
        checks_total++; if (dc_wr_valid !== 1'b0 || mem_wr_valid !== 1'b0) $display("FAIL rst_valids: got %0h/%0h want 0/0", dc_wr_valid, mem_wr_valid); else checks_passed++;
        checks_total++; if (sb_get_oldest !== 1'b0) $display("FAIL rst_pop: got %0h want 0", sb_get_oldest); else checks_passed++;
        checks_total++; if (dc_wr_byte_en !== 4'h0 || dc_wr_data !== 32'h0 || mem_wr_addr !== 20'h0) $display("FAIL rst_payload: got be=%0h data=%0h addr=%0h want 0", dc_wr_byte_en, dc_wr_data, mem_wr_addr); else checks_passed++;
        checks_total++; if (dbg_state !== 3'd0) $display("FAIL rst_state: got %0d want 0", dbg_state); else checks_passed++;
`ifdef STORE_DRAIN_PERF_EN
        checks_total++; if (perf_stores !== 32'd0 || perf_misses !== 32'd0) $display("FAIL rst_perf: got %0d/%0d want 0/0", perf_stores, perf_misses); else checks_passed++;
`endif
        tick();
        reset = 1'b0;
    endtask

    task automatic test_word_hit();
        tick();
        sb_pending     = 1'b1;
        sb_oldest_info = make_entry(15'h1234, 5'h08, 2'd1, 2'd2, 32'hDEADBEEF);
        dc_wr_ready    = 1'b1;
        #1;
        checks_total++; if (sb_get_oldest !== 1'b1) $display("FAIL hit_pop: got %0h want 1", sb_get_oldest); else checks_passed++;
        tick();
        sb_pending = 1'b0;
        #1;
        checks_total++; if (dc_wr_valid !== 1'b1) $display("FAIL hit_valid: got %0h want 1", dc_wr_valid); else checks_passed++;
        checks_total++; if (dc_wr_word !== 3'd2 || dc_wr_byte_en !== 4'hF) $display("FAIL hit_lanes: got word=%0d be=%0h want 2/f", dc_wr_word, dc_wr_byte_en); else checks_passed++;
        checks_total++; if (dc_wr_data !== 32'hDEADBEEF) $display("FAIL hit_data: got %0h want deadbeef", dc_wr_data); else checks_passed++;
        checks_total++; if (dc_wr_tag !== 15'h1234 || dc_wr_way !== 2'd1) $display("FAIL hit_tagway: got %0h/%0d want 1234/1", dc_wr_tag, dc_wr_way); else checks_passed++;
        checks_total++; if (sb_get_oldest !== 1'b0) $display("FAIL hit_single_pop: got %0h want 0", sb_get_oldest); else checks_passed++;
        tick();
        #1;
        checks_total++; if (dc_wr_valid !== 1'b0 || busy !== 1'b1) $display("FAIL hit_wait: got valid=%0h busy=%0h want 0/1", dc_wr_valid, busy); else checks_passed++;
        dc_rsp_valid = 1'b1;
        dc_rsp_hit   = 1'b1;
        tick();
        dc_rsp_valid = 1'b0;
        dc_rsp_hit   = 1'b0;
        #1;
        checks_total++; if (busy !== 1'b0 || mem_wr_valid !== 1'b0) $display("FAIL hit_done: got busy=%0h memv=%0h want 0/0", busy, mem_wr_valid); else checks_passed++;
        clear_inputs();
    endtask

    task automatic test_byte_miss();
        tick();
        sb_pending     = 1'b1;
        sb_oldest_info = make_entry(15'h1234, 5'h03, 2'd0, 2'd0, 32'h000000AB);
        dc_wr_ready    = 1'b1;
        #1;
        checks_total++; if (sb_get_oldest !== 1'b1) $display("FAIL miss_pop: got %0h want 1", sb_get_oldest); else checks_passed++;
        tick();
        sb_pending = 1'b0;
        #1;
        checks_total++; if (dc_wr_byte_en !== 4'h8 || dc_wr_data !== 32'hAB000000 || dc_wr_word !== 3'd0) $display("FAIL miss_dc_payload: got be=%0h data=%0h word=%0d want 8/ab000000/0", dc_wr_byte_en, dc_wr_data, dc_wr_word); else checks_passed++;
        tick();
        dc_rsp_valid = 1'b1;
        dc_rsp_hit   = 1'b0;
        tick();
        dc_rsp_valid = 1'b0;
        #1;
        checks_total++; if (mem_wr_valid !== 1'b1) $display("FAIL miss_memv: got %0h want 1", mem_wr_valid); else checks_passed++;
        checks_total++; if (mem_wr_addr !== 20'h24683) $display("FAIL miss_addr: got %0h want 24683", mem_wr_addr); else checks_passed++;
        checks_total++; if (mem_wr_byte_en !== 4'h8 || mem_wr_data !== 32'hAB000000) $display("FAIL miss_mem_payload: got be=%0h data=%0h want 8/ab000000", mem_wr_byte_en, mem_wr_data); else checks_passed++;
        tick();
        #1;
        checks_total++; if (mem_wr_valid !== 1'b1) $display("FAIL miss_mem_hold: got %0h want 1", mem_wr_valid); else checks_passed++;
        mem_wr_ready = 1'b1;
        tick();
        mem_wr_ready = 1'b0;
        #1;
        checks_total++; if (mem_wr_valid !== 1'b0 || busy !== 1'b1) $display("FAIL miss_memwait: got memv=%0h busy=%0h want 0/1", mem_wr_valid, busy); else checks_passed++;
        tick();
        sb_pending = 1'b1;
        #1;
        checks_total++; if (sb_get_oldest !== 1'b0 || busy !== 1'b1) $display("FAIL miss_no_pop_before_ack: got pop=%0h busy=%0h want 0/1", sb_get_oldest, busy); else checks_passed++;
        mem_wr_ack = 1'b1;
        tick();
        mem_wr_ack = 1'b0;
        sb_pending = 1'b0;
        #1;
        checks_total++; if (busy !== 1'b0) $display("FAIL miss_ack_idle: got %0h want 0", busy); else checks_passed++;
        clear_inputs();
    endtask

    task automatic test_load_priority();
        dc_wr_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            sb_pending     = 1'b1;
            load_busy      = 1'b1;
            sb_full        = 1'b0;
            sb_oldest_info = make_entry(15'h0ABC, 5'h06, 2'd3, 2'd1, 32'h1234CAFE);
            #1;
            checks_total++; if (sb_get_oldest !== 1'b0) $display("FAIL prio_no_pop_%0d: got %0h want 0", i, sb_get_oldest); else checks_passed++;
        end
        tick();
        sb_full = 1'b1;
        #1;
        checks_total++; if (sb_get_oldest !== 1'b1) $display("FAIL prio_full_pop: got %0h want 1", sb_get_oldest); else checks_passed++;
        tick();
        sb_full    = 1'b0;
        sb_pending = 1'b0;
        #1;
        checks_total++; if (dc_wr_valid !== 1'b1 || dc_wr_byte_en !== 4'hC || dc_wr_word !== 3'd1 || dc_wr_way !== 2'd3) $display("FAIL prio_half_lanes: got v=%0h be=%0h word=%0d way=%0d want 1/c/1/3", dc_wr_valid, dc_wr_byte_en, dc_wr_word, dc_wr_way); else checks_passed++;
        checks_total++; if (dc_wr_data !== 32'hCAFE0000) $display("FAIL prio_half_data: got %0h want cafe0000", dc_wr_data); else checks_passed++;
        tick();
        dc_rsp_valid = 1'b1;
        dc_rsp_hit   = 1'b1;
        tick();
        #1;
        checks_total++; if (busy !== 1'b0) $display("FAIL prio_done: got %0h want 0", busy); else checks_passed++;
        clear_inputs();
    endtask

    task automatic test_backpressure();
        int pops;
        pops = 0;
        tick();
        sb_pending     = 1'b1;
        sb_oldest_info = make_entry(15'h0007, 5'h11, 2'd2, 2'd0, 32'hFFFFFF5A);
        dc_wr_ready    = 1'b0;
        #1;
        if (sb_get_oldest === 1'b1) pops++;
        for (int i = 0; i < 4; i++) begin
            tick();
            #1;
            if (sb_get_oldest === 1'b1) pops++;
            checks_total++; if (dc_wr_valid !== 1'b1 || dc_wr_byte_en !== 4'h2 || dc_wr_data !== 32'h00005A00 || dc_wr_word !== 3'd4 || dc_wr_tag !== 15'h0007) $display("FAIL bp_hold_%0d: got v=%0h be=%0h data=%0h word=%0d tag=%0h want 1/2/00005a00/4/7", i, dc_wr_valid, dc_wr_byte_en, dc_wr_data, dc_wr_word, dc_wr_tag); else checks_passed++;
        end
        dc_wr_ready = 1'b1;
        tick();
        sb_pending  = 1'b0;
        dc_wr_ready = 1'b0;
        #1;
        if (sb_get_oldest === 1'b1) pops++;
        checks_total++; if (dc_wr_valid !== 1'b0) $display("FAIL bp_release: got %0h want 0", dc_wr_valid); else checks_passed++;
        dc_rsp_valid = 1'b1;
        dc_rsp_hit   = 1'b1;
        tick();
        dc_rsp_valid = 1'b0;
        #1;
        checks_total++; if (pops !== 1 || busy !== 1'b0) $display("FAIL bp_pops: got pops=%0d busy=%0h want 1/0", pops, busy); else checks_passed++;
        clear_inputs();
    endtask

    task automatic test_drain();
        logic [55:0] e0;
        logic [55:0] e1;
        e0 = make_entry(15'h0001, 5'h00, 2'd0, 2'd2, 32'h11111111);
        e1 = make_entry(15'h0002, 5'h04, 2'd2, 2'd2, 32'h22222222);
        for (int c = 0; c < 8; c++) begin
            tick();
            drain_req      = 1'b1;
            load_busy      = 1'b1;
            dc_wr_ready    = 1'b1;
            dc_rsp_valid   = 1'b1;
            dc_rsp_hit     = 1'b1;
            sb_pending     = (c <= 3);
            sb_oldest_info = (c == 0) ? e0 : e1;
            #1;
            checks_total++; if (sb_get_oldest !== ((c == 0) || (c == 3))) $display("FAIL drain_pop_c%0d: got %0h want %0h", c, sb_get_oldest, ((c == 0) || (c == 3))); else checks_passed++;
            checks_total++; if (drain_done !== (c >= 6)) $display("FAIL drain_done_c%0d: got %0h want %0h", c, drain_done, (c >= 6)); else checks_passed++;
            if (c == 1) begin
                checks_total++; if (dc_wr_data !== 32'h11111111 || dc_wr_word !== 3'd0) $display("FAIL drain_first: got %0h/%0d want 11111111/0", dc_wr_data, dc_wr_word); else checks_passed++;
            end
            if (c == 4) begin
                checks_total++; if (dc_wr_data !== 32'h22222222 || dc_wr_word !== 3'd1) $display("FAIL drain_second: got %0h/%0d want 22222222/1", dc_wr_data, dc_wr_word); else checks_passed++;
            end
        end
        tick();
        drain_req = 1'b0;
        #1;
        checks_total++; if (drain_done !== 1'b0) $display("FAIL drain_release: got %0h want 0", drain_done); else checks_passed++;
        clear_inputs();
    endtask

    task automatic test_reset_mid_op();
        tick();
        sb_pending     = 1'b1;
        sb_oldest_info = make_entry(15'h7FFF, 5'h1F, 2'd3, 2'd1, 32'h0000BEEF);
        dc_wr_ready    = 1'b1;
        #1;
        checks_total++; if (sb_get_oldest !== 1'b1) $display("FAIL rmo_pop: got %0h want 1", sb_get_oldest); else checks_passed++;
        tick();
        sb_pending   = 1'b0;
        dc_rsp_valid = 1'b1;
        dc_rsp_hit   = 1'b0;
        mem_wr_ready = 1'b1;
        tick();
        tick();
        tick();
        #1;
        checks_total++; if (dbg_state !== 3'd4 || mem_wr_addr !== 20'hFFFFF || mem_wr_byte_en !== 4'hC) $display("FAIL rmo_memwait: got st=%0d addr=%0h be=%0h want 4/fffff/c", dbg_state, mem_wr_addr, mem_wr_byte_en); else checks_passed++;
`ifdef STORE_DRAIN_PERF_EN
        checks_total++; if (perf_stores !== 32'd6 || perf_misses !== 32'd2) $display("FAIL rmo_perf_pre: got %0d/%0d want 6/2", perf_stores, perf_misses); else checks_passed++;
`endif
        reset        = 1'b1;
        dc_rsp_valid = 1'b0;
        mem_wr_ready = 1'b0;
        tick();
        reset = 1'b0;
        #1;
        checks_total++; if (busy !== 1'b0 || dbg_state !== 3'd0) $display("FAIL rmo_idle: got busy=%0h st=%0d want 0/0", busy, dbg_state); else checks_passed++;
        checks_total++; if (dc_wr_valid !== 1'b0 || mem_wr_valid !== 1'b0 || sb_get_oldest !== 1'b0) $display("FAIL rmo_valids: got %0h/%0h/%0h want 0/0/0", dc_wr_valid, mem_wr_valid, sb_get_oldest); else checks_passed++;
        checks_total++; if (mem_wr_addr !== 20'h0 || dc_wr_data !== 32'h0) $display("FAIL rmo_payload: got addr=%0h data=%0h want 0/0", mem_wr_addr, dc_wr_data); else checks_passed++;
`ifdef STORE_DRAIN_PERF_EN
        checks_total++; if (perf_stores !== 32'd0 || perf_misses !== 32'd0) $display("FAIL rmo_perf: got %0d/%0d want 0/0", perf_stores, perf_misses); else checks_passed++;
`endif
        mem_wr_ack = 1'b1;
        tick();
        mem_wr_ack = 1'b0;
        #1;
        checks_total++; if (busy !== 1'b0 || dbg_state !== 3'd0) $display("FAIL rmo_stray_ack: got busy=%0h st=%0d want 0/0", busy, dbg_state); else checks_passed++;
        clear_inputs();
    endtask

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        test_reset();
        test_word_hit();
        test_byte_miss();
        test_load_priority();
        test_backpressure();
        test_drain();
        test_reset_mid_op();
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
